// File: rtl/key_debounce_pkg.sv
// ==== key_debounce_pkg : shared state encodings for the key debouncer (rev 1.0) ====
`default_nettype none

package key_debounce_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } key_state_t;
endpackage

`default_nettype wire

// File: rtl/key_debounce_sync_2ff.sv
// ==== sync_2ff : two-flop synchronizer with configurable reset level (rev 1.0) ====
`default_nettype none

module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ==== key_debounce : push-button debouncer with press/release/long-press pulses (rev 1.0) ====
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 26
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               KEY_IN,
  output logic               KEY,
  output logic               KEY_REL,
  output logic               KEY_LONG,
  output logic               KEY_LEVEL,
  output logic [STATE_W-1:0] STATE
);
  localparam bit               INVERT    = (ACTIVE_LOW != 0);
  localparam bit               LONG_EN   = (LONG_CYCLES > 0);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_EN ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(0);

  logic raw_sync;
  logic sync;

  // Reset the synchronizer to the raw released level so no false press is seen.
  sync_2ff #(.RESET_VAL(INVERT)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (KEY_IN),
    .q     (raw_sync)
  );

  assign sync = INVERT ? ~raw_sync : raw_sync;

  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] rel_cnt, rel_cnt_nxt;
  logic             long_fired, long_fired_nxt;
  logic             key_nxt, rel_nxt, long_nxt, level_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rel_cnt    <= '0;
      long_fired <= 1'b0;
      KEY        <= 1'b0;
      KEY_REL    <= 1'b0;
      KEY_LONG   <= 1'b0;
      KEY_LEVEL  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rel_cnt    <= rel_cnt_nxt;
      long_fired <= long_fired_nxt;
      KEY        <= key_nxt;
      KEY_REL    <= rel_nxt;
      KEY_LONG   <= long_nxt;
      KEY_LEVEL  <= level_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    rel_cnt_nxt    = rel_cnt;
    long_fired_nxt = long_fired;
    key_nxt        = 1'b0;
    rel_nxt        = 1'b0;
    long_nxt       = 1'b0;
    level_nxt      = KEY_LEVEL;
    case (state)
      ST_IDLE: begin
        if (sync) begin
          state_nxt = ST_PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!sync) begin
          state_nxt = ST_IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = ST_HELD;
          key_nxt   = 1'b1;
          level_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        // Long-press check runs even on the edge that leaves for REL_CHK.
        if (LONG_EN) begin
          if (cnt != LONG_LAST) begin
            cnt_nxt = cnt + CNT_W'(1);
          end else if (!long_fired) begin
            long_nxt       = 1'b1;
            long_fired_nxt = 1'b1;
          end
        end
        if (!sync) begin
          state_nxt   = ST_REL_CHK;
          rel_cnt_nxt = '0;
        end
      end
      ST_REL_CHK: begin
        if (sync) begin
          state_nxt = ST_HELD;
        end else if (rel_cnt == DEB_LAST) begin
          state_nxt      = ST_IDLE;
          rel_nxt        = 1'b1;
          level_nxt      = 1'b0;
          long_fired_nxt = 1'b0;
        end else begin
          rel_cnt_nxt = rel_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign STATE = state;
endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ==== tb_key_debounce : directed + randomized bench for key_debounce (rev 1.0) ====
`default_nettype none

module tb_key_debounce;
  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b1;
  logic       key, key_rel, key_long, key_level;
  logic [1:0] state;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1),
    .CNT_W           (8)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .KEY_IN    (key_in),
    .KEY       (key),
    .KEY_REL   (key_rel),
    .KEY_LONG  (key_long),
    .KEY_LEVEL (key_level),
    .STATE     (state)
  );

  // Reference model: debounced level plus run-length of disagreeing sync samples.
  bit sh1, sh2, m_level, long_done;
  int run, held_edges;
  bit e_key, e_rel, e_long;

  int total = 0;
  int bad = 0;
  int idx, n_key, n_rel, n_long, key_at, rel_at, long_at;

  task automatic model_edge(input bit k, input bit r);
    bit s;
    e_key = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (!r) begin
      sh1 = 1'b0; sh2 = 1'b0; m_level = 1'b0; long_done = 1'b0;
      run = 0; held_edges = 0;
    end else begin
      s = sh2;
      if (!m_level) begin
        if (s) begin
          run++;
          if (run == D + 1) begin
            m_level = 1'b1; e_key = 1'b1; run = 0; held_edges = 0;
          end
        end else run = 0;
      end else begin
        if (run == 0) begin
          held_edges++;
          if (L > 0 && held_edges == L && !long_done) begin
            e_long = 1'b1; long_done = 1'b1;
          end
        end
        if (!s) begin
          run++;
          if (run == D + 1) begin
            m_level = 1'b0; e_rel = 1'b1; run = 0; long_done = 1'b0;
          end
        end else run = 0;
      end
      sh2 = sh1;
      sh1 = ~k;
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (!m_level) return (run == 0) ? 32'd0 : 32'd1;
    return (run == 0) ? 32'd2 : 32'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic win_start();
    idx = 0; n_key = 0; n_rel = 0; n_long = 0;
    key_at = -1; rel_at = -1; long_at = -1;
  endtask

  task automatic step(input bit k, input bit r);
    key_in = k;
    rst_n  = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    chk("key",   {31'd0, key},       {31'd0, e_key});
    chk("rel",   {31'd0, key_rel},   {31'd0, e_rel});
    chk("long",  {31'd0, key_long},  {31'd0, e_long});
    chk("level", {31'd0, key_level}, {31'd0, m_level});
    chk("state", {30'd0, state},     exp_state());
    chk("excl",  {31'd0, $onehot0({key, key_rel, key_long})}, 32'd1);
    idx++;
    if (key === 1'b1)      begin n_key++;  key_at  = idx; end
    if (key_rel === 1'b1)  begin n_rel++;  rel_at  = idx; end
    if (key_long === 1'b1) begin n_long++; long_at = idx; end
    @(negedge clk);
  endtask

  task automatic hold(input bit k, input int n);
    repeat (n) step(k, 1'b1);
  endtask

  initial begin
    int n;
    bit k;
    win_start();
    @(negedge clk);

    // Reset with toggling input
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    chk("rst_state", {30'd0, state}, 32'd0);
    hold(1'b1, 4);

    // Clean press
    win_start();
    hold(1'b0, 20);
    chk("press_count", n_key, 32'd1);
    chk("press_edge", key_at, 32'd7);
    chk("press_state", {30'd0, state}, 32'd2);
    hold(1'b1, 10);

    // Bounce
    win_start();
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 8);
    chk("bounce_count", n_key, 32'd0);
    chk("bounce_level", {31'd0, key_level}, 32'd0);
    chk("bounce_state", {30'd0, state}, 32'd0);

    // Long hold then release
    win_start();
    hold(1'b0, 30); hold(1'b1, 10);
    chk("long_keys", n_key, 32'd1);
    chk("long_count", n_long, 32'd1);
    chk("long_edge", long_at, 32'd17);
    chk("long_rel_count", n_rel, 32'd1);
    chk("long_rel_edge", rel_at, 32'd37);
    chk("long_level", {31'd0, key_level}, 32'd0);

    // Release glitch while held
    win_start();
    hold(1'b0, 12); hold(1'b1, 2); hold(1'b0, 6);
    chk("glitch_keys", n_key, 32'd1);
    chk("glitch_rel", n_rel, 32'd0);
    chk("glitch_state", {30'd0, state}, 32'd2);
    hold(1'b1, 10);

    // Reset while held, key stays pressed
    hold(1'b0, 10);
    step(1'b0, 1'b0);
    chk("hrst_level", {31'd0, key_level}, 32'd0);
    chk("hrst_state", {30'd0, state}, 32'd0);
    win_start();
    hold(1'b0, 12);
    chk("hrst_keys", n_key, 32'd1);
    chk("hrst_edge", key_at, 32'd7);
    chk("hrst_rel", n_rel, 32'd0);
    hold(1'b1, 10);

    // Randomized segments with occasional reset
    repeat (60) begin
      k = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) step(k, 1'b0);
      hold(k, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
